// File: rtl/gnt_dispatch_pkg.sv
// Shared sizing and types for the grant dispatcher and its clients.
package gnt_dispatch_pkg;

  localparam int unsigned N_LANES   = 8;
  localparam int unsigned CNT_DEPTH = 4;
  localparam int unsigned IDX_W     = $clog2(N_LANES);
  localparam int unsigned CNT_W     = $clog2(CNT_DEPTH + 1);

  typedef logic [IDX_W-1:0]   lane_idx_t;
  typedef logic [CNT_W-1:0]   cnt_t;
  typedef logic [N_LANES-1:0] lane_vec_t;

endpackage

// File: rtl/gnt_dispatch_if.sv
// Request/grant/dispatch bundle between clients, the selector tree and gnt_dispatch.
interface gnt_dispatch_if #(
  parameter int unsigned N_LANES = gnt_dispatch_pkg::N_LANES
);
  import gnt_dispatch_pkg::*;

  localparam int unsigned IDX_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;

  logic [N_LANES-1:0] push;
  logic [N_LANES-1:0] lane_full;
  logic [N_LANES-1:0] req;
  logic               en;
  logic [N_LANES-1:0] gnt;
  logic               out_valid;
  logic [IDX_W-1:0]   out_idx;
  logic               out_ready;
  logic               gnt_err;

  modport master (
    output push, gnt, out_ready,
    input  lane_full, req, en, out_valid, out_idx, gnt_err
  );

  modport slave (
    input  push, gnt, out_ready,
    output lane_full, req, en, out_valid, out_idx, gnt_err
  );

endinterface

// File: rtl/gnt_dispatch_onehot_enc.sv
// One-hot to binary encoder with a legality flag for grant consumers.
module onehot_enc #(
  parameter  int unsigned N_LANES = 8,
  localparam int unsigned IDX_W   = (N_LANES > 1) ? $clog2(N_LANES) : 1
) (
  input  logic [N_LANES-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               valid,
  output logic               onehot_ok
);
  import gnt_dispatch_pkg::*;

  always_comb begin
    idx = '0;
    for (int unsigned i = 0; i < N_LANES; i++) begin
      if (gnt[i]) idx = idx | IDX_W'(i);
    end
  end

  assign valid     = |gnt;
  // Clearing the lowest set bit leaves zero only for zero or one-hot input.
  assign onehot_ok = ((gnt & (gnt - N_LANES'(1))) == '0);

endmodule

// File: rtl/gnt_dispatch.sv
// Per-lane pending counters feeding a priority selector; encodes the returned
// grant and presents the winning lane index on a registered valid/ready port.
module gnt_dispatch #(
  parameter int unsigned N_LANES   = gnt_dispatch_pkg::N_LANES,
  parameter int unsigned CNT_DEPTH = gnt_dispatch_pkg::CNT_DEPTH
) (
  input  logic           clock,
  input  logic           reset,
  gnt_dispatch_if.slave  bus
);
  import gnt_dispatch_pkg::*;

  localparam int unsigned IDX_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;
  localparam int unsigned CNT_W = $clog2(CNT_DEPTH + 1);

  logic [N_LANES-1:0] req_v;
  logic [N_LANES-1:0] full_v;
  logic [N_LANES-1:0] grant_v;
  logic [IDX_W-1:0]   enc_idx;
  logic               gnt_any;
  logic               gnt_onehot;
  logic               en;
  logic               accept;
  logic               illegal;
  logic               out_valid_q;
  logic [IDX_W-1:0]   out_idx_q;
  logic               gnt_err_q;

  onehot_enc #(.N_LANES(N_LANES)) u_enc (
    .gnt       (bus.gnt),
    .idx       (enc_idx),
    .valid     (gnt_any),
    .onehot_ok (gnt_onehot)
  );

  assign en      = ~out_valid_q | bus.out_ready;
  assign accept  = en & gnt_any & gnt_onehot & (|(bus.gnt & req_v));
  assign illegal = gnt_any & ~accept;
  assign grant_v = accept ? bus.gnt : '0;

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    logic [CNT_W-1:0] cnt;
    logic             push_ok;

    // A full lane still takes a push when it is being granted this cycle.
    assign push_ok = bus.push[i] & ((cnt != CNT_W'(CNT_DEPTH)) | grant_v[i]);

    always_ff @(posedge clock) begin
      if (reset) begin
        cnt <= '0;
      end else if (push_ok && !grant_v[i]) begin
        cnt <= cnt + CNT_W'(1);
      end else if (!push_ok && grant_v[i]) begin
        cnt <= cnt - CNT_W'(1);
      end
    end

    assign req_v[i]  = (cnt != '0);
    assign full_v[i] = (cnt == CNT_W'(CNT_DEPTH));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      gnt_err_q   <= 1'b0;
    end else begin
      if (accept) begin
        out_valid_q <= 1'b1;
        out_idx_q   <= enc_idx;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (illegal) gnt_err_q <= 1'b1;
    end
  end

  assign bus.req       = req_v;
  assign bus.lane_full = full_v;
  assign bus.en        = en;
  assign bus.out_valid = out_valid_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.gnt_err   = gnt_err_q;

endmodule

// File: tb/tb_gnt_dispatch.sv
// Directed bench: gnt_dispatch with a highest-index-wins selector attached,
// plus a forced-grant mode for illegal grant patterns.
module tb_gnt_dispatch;
  import gnt_dispatch_pkg::*;

  logic      clock = 1'b0;
  logic      reset = 1'b1;
  logic      force_en = 1'b0;
  lane_vec_t force_val = '0;
  int        n_checks = 0;
  int        n_fail = 0;

  gnt_dispatch_if #(.N_LANES(N_LANES)) bus ();

  gnt_dispatch #(.N_LANES(N_LANES), .CNT_DEPTH(CNT_DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic lane_vec_t ps8(input lane_vec_t r);
    lane_vec_t g;
    logic      found;
    g = '0;
    found = 1'b0;
    for (int i = N_LANES - 1; i >= 0; i--) begin
      if (r[i] && !found) begin
        g[i] = 1'b1;
        found = 1'b1;
      end
    end
    return g;
  endfunction

  assign bus.gnt = force_en ? force_val : (bus.en ? ps8(bus.req) : '0);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    bus.push      = '0;
    bus.out_ready = 1'b1;
    repeat (2) tick();
    reset = 1'b0;

    // reset then idle
    for (int i = 0; i < 5; i++) begin
      check_eq("idle_req", bus.req, 32'h00);
      check_eq("idle_en", bus.en, 1);
      check_eq("idle_valid", bus.out_valid, 0);
      check_eq("idle_idx", bus.out_idx, 0);
      check_eq("idle_err", bus.gnt_err, 0);
      check_eq("idle_full", bus.lane_full, 32'h00);
      tick();
    end

    // single lane
    bus.push = 8'h20;
    tick();
    bus.push = '0;
    check_eq("single_req", bus.req, 32'h20);
    tick();
    check_eq("single_valid", bus.out_valid, 1);
    check_eq("single_idx", bus.out_idx, 5);
    check_eq("single_req0", bus.req, 32'h00);
    tick();
    check_eq("single_drop", bus.out_valid, 0);

    // priority and backpressure
    bus.out_ready = 1'b0;
    bus.push = 8'h44;
    tick();
    bus.push = '0;
    check_eq("prio_req", bus.req, 32'h44);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("bp_valid", bus.out_valid, 1);
      check_eq("bp_idx", bus.out_idx, 6);
      check_eq("bp_en", bus.en, 0);
      check_eq("bp_req", bus.req, 32'h04);
    end
    bus.out_ready = 1'b1;
    tick();
    check_eq("prio2_valid", bus.out_valid, 1);
    check_eq("prio2_idx", bus.out_idx, 2);
    check_eq("prio2_req", bus.req, 32'h00);
    tick();
    check_eq("prio_done", bus.out_valid, 0);

    // saturation: first push is dispatched into the held output, rest fill lane 0
    bus.out_ready = 1'b0;
    bus.push = 8'h01;
    repeat (7) tick();
    bus.push = '0;
    check_eq("sat_full", bus.lane_full, 32'h01);
    check_eq("sat_req", bus.req, 32'h01);
    check_eq("sat_en", bus.en, 0);
    check_eq("sat_valid", bus.out_valid, 1);
    check_eq("sat_idx", bus.out_idx, 0);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq("drain_valid", bus.out_valid, 1);
      check_eq("drain_idx", bus.out_idx, 0);
      check_eq("drain_req", bus.req, (k < 3) ? 32'h01 : 32'h00);
      check_eq("drain_full", bus.lane_full, 32'h00);
    end
    tick();
    check_eq("drain_end", bus.out_valid, 0);

    // same-lane push and grant at full depth
    bus.out_ready = 1'b0;
    bus.push = 8'h08;
    repeat (5) tick();
    check_eq("same_fill", bus.lane_full, 32'h08);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_eq("same_full", bus.lane_full, 32'h08);
      check_eq("same_valid", bus.out_valid, 1);
      check_eq("same_idx", bus.out_idx, 3);
    end
    bus.push = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("same_drain", bus.out_valid, 1);
      check_eq("same_didx", bus.out_idx, 3);
    end
    check_eq("same_req0", bus.req, 32'h00);
    tick();
    check_eq("same_end", bus.out_valid, 0);

    // illegal grants
    bus.out_ready = 1'b0;
    force_en = 1'b1;
    force_val = '0;
    check_eq("ill_err0", bus.gnt_err, 0);
    bus.push = 8'h04;
    tick();
    bus.push = '0;
    check_eq("ill_req", bus.req, 32'h04);
    force_val = 8'h0C;
    tick();
    check_eq("multi_err", bus.gnt_err, 1);
    check_eq("multi_valid", bus.out_valid, 0);
    check_eq("multi_req", bus.req, 32'h04);
    force_val = '0;
    repeat (3) tick();
    check_eq("err_sticky", bus.gnt_err, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("rst_err", bus.gnt_err, 0);
    check_eq("rst_req", bus.req, 32'h00);

    bus.push = 8'h04;
    tick();
    bus.push = '0;
    force_val = 8'h01;
    tick();
    check_eq("noreq_err", bus.gnt_err, 1);
    check_eq("noreq_valid", bus.out_valid, 0);
    check_eq("noreq_req", bus.req, 32'h04);
    force_val = 8'h04;
    tick();
    check_eq("legal_valid", bus.out_valid, 1);
    check_eq("legal_idx", bus.out_idx, 2);
    check_eq("legal_req", bus.req, 32'h00);
    check_eq("legal_err", bus.gnt_err, 1);
    force_val = '0;
    bus.push = 8'h04;
    tick();
    bus.push = '0;
    force_val = 8'h04;
    tick();
    check_eq("blk_valid", bus.out_valid, 1);
    check_eq("blk_req", bus.req, 32'h04);
    check_eq("blk_err", bus.gnt_err, 1);
    force_val = '0;
    force_en = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("fin_err", bus.gnt_err, 0);
    check_eq("fin_valid", bus.out_valid, 0);
    check_eq("fin_req", bus.req, 32'h00);
    check_eq("fin_en", bus.en, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
